// File: rtl/stripe_mode_sequencer.sv
// stripe_mode_sequencer
//   Owns the address-stripe mode register (0 linear, 1 512 KiB, 2 1 MiB) that
//   drives the stripe remap block. A soft-register mode write closes AR/AW
//   admission, waits for all outstanding reads/writes to complete, switches
//   the mode for one cycle, then reopens admission.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   sr_req_*            soft-register request (valid, is_write, addr, data)
//   sr_resp_valid/data  status read response, one cycle after the read
//   m_ar*/s_ar*         upstream/downstream AR handshake (gated pass-through)
//   m_aw*/s_aw*         upstream/downstream AW handshake (gated pass-through)
//   rvalid/rready/rlast R channel observation (read completion on rlast)
//   bvalid/bready       B channel observation (write completion)
//   mode                current stripe mode to the remap block
module stripe_mode_sequencer #(
  parameter logic [1:0]  INIT_MODE    = 2'd0,
  parameter logic [31:0] SR_ADDR      = 32'h30,
  parameter logic [31:0] SR_STAT_ADDR = 32'h38,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sr_req_valid,
  input  logic        sr_req_is_write,
  input  logic [31:0] sr_req_addr,
  input  logic [63:0] sr_req_data,
  output logic        sr_resp_valid,
  output logic [63:0] sr_resp_data,
  input  logic        m_arvalid,
  output logic        m_arready,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic        m_awvalid,
  output logic        m_awready,
  output logic        s_awvalid,
  input  logic        s_awready,
  input  logic        rvalid,
  input  logic        rready,
  input  logic        rlast,
  input  logic        bvalid,
  input  logic        bready,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       r_pend;
  logic             r_err;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic             r_ar_inflight;
  logic             r_aw_inflight;
  logic             r_resp_valid;
  logic [63:0]      r_resp_data;

  logic             w_mode_wr;
  logic             w_mode_bad;
  logic             w_mode_ok;
  logic [1:0]       w_wr_val;
  logic             w_stat_rd;
  logic             w_ar_open;
  logic             w_aw_open;
  logic             w_ar_hs;
  logic             w_aw_hs;
  logic             w_rd_done;
  logic             w_wr_done;
  logic             w_quiet;
  logic [7:0]       w_rd8;
  logic [7:0]       w_wr8;

  assign w_mode_wr  = sr_req_valid & sr_req_is_write & (sr_req_addr == SR_ADDR);
  assign w_mode_bad = (sr_req_data[1:0] == 2'd3) | (|sr_req_data[63:2]);
  assign w_mode_ok  = w_mode_wr & ~w_mode_bad;
  assign w_wr_val   = sr_req_data[1:0];
  assign w_stat_rd  = sr_req_valid & ~sr_req_is_write & (sr_req_addr == SR_STAT_ADDR);

  assign w_ar_hs    = s_arvalid & s_arready;
  assign w_aw_hs    = s_awvalid & s_awready;
  assign w_rd_done  = rvalid & rready & rlast;
  assign w_wr_done  = bvalid & bready;
  assign w_quiet    = (r_rd_cnt == '0) & (r_wr_cnt == '0) & ~r_ar_inflight & ~r_aw_inflight;

  assign w_rd8      = 8'(r_rd_cnt);
  assign w_wr8      = 8'(r_wr_cnt);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // A presented-but-unaccepted request keeps its gate open in every state,
  // so valid is never withdrawn once it has been driven downstream.
  always_comb begin
    w_state_nxt = r_state;
    w_ar_open   = r_ar_inflight;
    w_aw_open   = r_aw_inflight;
    case (r_state)
      ST_RUN: begin
        if (r_rd_cnt != CNT_MAX) w_ar_open = 1'b1;
        if (r_wr_cnt != CNT_MAX) w_aw_open = 1'b1;
        if (w_mode_ok && (w_wr_val != r_mode)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_quiet) w_state_nxt = ST_SWITCH;
      end
      ST_SWITCH: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
    s_arvalid = m_arvalid & w_ar_open;
    m_arready = s_arready & w_ar_open;
    s_awvalid = m_awvalid & w_aw_open;
    m_awready = s_awready & w_aw_open;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode        <= INIT_MODE;
      r_pend        <= INIT_MODE;
      r_err         <= 1'b0;
      r_rd_cnt      <= '0;
      r_wr_cnt      <= '0;
      r_ar_inflight <= 1'b0;
      r_aw_inflight <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
    end else begin
      // Nothing can be outstanding in SWITCH, so a write landing there is
      // applied directly instead of being stranded in the pending register.
      if (r_state == ST_SWITCH) r_mode <= w_mode_ok ? w_wr_val : r_pend;
      if (w_mode_ok) r_pend <= w_wr_val;

      if (w_mode_wr && w_mode_bad) r_err <= 1'b1;
      else if (w_stat_rd)          r_err <= 1'b0;

      if (w_ar_hs && !w_rd_done)      r_rd_cnt <= r_rd_cnt + CNT_ONE;
      else if (!w_ar_hs && w_rd_done) r_rd_cnt <= r_rd_cnt - CNT_ONE;

      if (w_aw_hs && !w_wr_done)      r_wr_cnt <= r_wr_cnt + CNT_ONE;
      else if (!w_aw_hs && w_wr_done) r_wr_cnt <= r_wr_cnt - CNT_ONE;

      r_ar_inflight <= s_arvalid & ~s_arready;
      r_aw_inflight <= s_awvalid & ~s_awready;

      r_resp_valid <= w_stat_rd;
      if (w_stat_rd) begin
        r_resp_data <= {33'h0, w_wr8, w_rd8, 9'h0, r_err,
                        (r_state != ST_RUN), r_pend, r_mode};
      end
    end
  end

  assign sr_resp_valid = r_resp_valid;
  assign sr_resp_data  = r_resp_data;
  assign mode          = r_mode;

endmodule

// File: tb/tb_stripe_mode_sequencer.sv
module tb_stripe_mode_sequencer;
  localparam int unsigned CNT_W = 8;
  localparam int          CMAX  = 255;
  localparam logic [1:0]  IMODE = 2'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sr_req_valid, sr_req_is_write;
  logic [31:0] sr_req_addr;
  logic [63:0] sr_req_data;
  logic        sr_resp_valid;
  logic [63:0] sr_resp_data;
  logic        m_arvalid, m_arready, s_arvalid, s_arready;
  logic        m_awvalid, m_awready, s_awvalid, s_awready;
  logic        rvalid, rready, rlast, bvalid, bready;
  logic [1:0]  mode;

  stripe_mode_sequencer #(
    .INIT_MODE(IMODE), .SR_ADDR(32'h30), .SR_STAT_ADDR(32'h38), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .sr_req_valid(sr_req_valid), .sr_req_is_write(sr_req_is_write),
    .sr_req_addr(sr_req_addr), .sr_req_data(sr_req_data),
    .sr_resp_valid(sr_resp_valid), .sr_resp_data(sr_resp_data),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .bvalid(bvalid), .bready(bready),
    .mode(mode)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: mode-change phase 0 = admitting, 1 = waiting for quiet,
  // 2 = flip cycle; counts of outstanding reads/writes as plain integers.
  logic [1:0]  e_mode, e_pend;
  bit          e_err, e_ar_wait, e_aw_wait;
  int          e_rd, e_wr, phase;
  bit          ar_held, aw_held, last_ar_fire;
  logic [63:0] exp_q[$];

  task automatic model_reset();
    e_mode = IMODE; e_pend = IMODE; e_err = 0;
    e_rd = 0; e_wr = 0; phase = 0;
    e_ar_wait = 0; e_aw_wait = 0;
    ar_held = 0; aw_held = 0; last_ar_fire = 0;
  endtask

  function automatic logic [63:0] status_word();
    logic [63:0] w;
    w = '0;
    w[1:0]   = e_mode;
    w[3:2]   = e_pend;
    w[4]     = (phase != 0);
    w[5]     = e_err;
    w[22:15] = 8'(e_rd);
    w[30:23] = 8'(e_wr);
    return w;
  endfunction

  task automatic step();
    bit ar_pass, aw_pass, ar_fire, aw_fire, rd_done, wr_done;
    bit hit, bad, good, stat, quiet;
    logic [1:0] val;
    logic [5:0] exp_g, act_g;
    ar_pass = (phase == 0 && e_rd != CMAX) || e_ar_wait;
    aw_pass = (phase == 0 && e_wr != CMAX) || e_aw_wait;
    exp_g = {m_arvalid & ar_pass, s_arready & ar_pass,
             m_awvalid & aw_pass, s_awready & aw_pass, e_mode};
    act_g = {s_arvalid, m_arready, s_awvalid, m_awready, mode};
    check("gates", 64'(act_g), 64'(exp_g));
    if (rst) begin
      model_reset();
      return;
    end
    ar_fire = m_arvalid & ar_pass & s_arready;
    aw_fire = m_awvalid & aw_pass & s_awready;
    rd_done = rvalid & rready & rlast;
    wr_done = bvalid & bready;
    hit  = sr_req_valid & sr_req_is_write & (sr_req_addr == 32'h30);
    bad  = (sr_req_data[1:0] == 2'd3) || (sr_req_data[63:2] != '0);
    good = hit & !bad;
    val  = sr_req_data[1:0];
    stat = sr_req_valid & !sr_req_is_write & (sr_req_addr == 32'h38);
    if (stat) exp_q.push_back(status_word());
    quiet = (e_rd == 0) && (e_wr == 0) && !e_ar_wait && !e_aw_wait;
    case (phase)
      0: if (good && val != e_mode) phase = 1;
      1: if (quiet) phase = 2;
      default: begin
        e_mode = good ? val : e_pend;
        phase  = 0;
      end
    endcase
    if (good) e_pend = val;
    if (hit && bad) e_err = 1;
    else if (stat)  e_err = 0;
    e_rd = e_rd + int'(ar_fire) - int'(rd_done);
    e_wr = e_wr + int'(aw_fire) - int'(wr_done);
    e_ar_wait = m_arvalid & ar_pass & !s_arready;
    e_aw_wait = m_awvalid & aw_pass & !s_awready;
    ar_held = m_arvalid & !ar_fire;
    aw_held = m_awvalid & !aw_fire;
    last_ar_fire = ar_fire;
  endtask

  // Inputs are applied just after a negedge; the model steps before the edge.
  task automatic tick();
    #1;
    step();
    @(negedge clk);
    sr_req_valid = 0;
  endtask

  task automatic sr_wr(input logic [63:0] d);
    sr_req_valid = 1; sr_req_is_write = 1; sr_req_addr = 32'h30; sr_req_data = d;
  endtask

  task automatic sr_rd();
    sr_req_valid = 1; sr_req_is_write = 0; sr_req_addr = 32'h38; sr_req_data = '0;
  endtask

  task automatic all_idle();
    sr_req_valid = 0; sr_req_is_write = 0; sr_req_addr = '0; sr_req_data = '0;
    m_arvalid = 0; s_arready = 0; m_awvalid = 0; s_awready = 0;
    rvalid = 0; rready = 0; rlast = 0; bvalid = 0; bready = 0;
  endtask

  task automatic rand_cycle(input int p_req, input int p_done, input int p_sr);
    int c;
    if (!ar_held) m_arvalid = ($urandom_range(99) < p_req);
    if (!aw_held) m_awvalid = ($urandom_range(99) < p_req);
    s_arready = 1'($urandom_range(1));
    s_awready = 1'($urandom_range(1));
    rvalid = (e_rd > 0) && ($urandom_range(99) < p_done);
    rready = 1'($urandom_range(1));
    rlast  = 1'($urandom_range(1));
    bvalid = (e_wr > 0) && ($urandom_range(99) < p_done);
    bready = 1'($urandom_range(1));
    if ($urandom_range(99) < p_sr) begin
      c = $urandom_range(9);
      if (c <= 3)      sr_wr(64'($urandom_range(2)));
      else if (c == 4) sr_wr(64'd3);
      else if (c == 5) sr_wr({32'h0, 28'h0, 4'h4} | 64'($urandom_range(2)));
      else if (c <= 8) sr_rd();
      else begin
        sr_wr(64'($urandom_range(2)));
        sr_req_addr = 32'h40;
      end
    end
    tick();
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (sr_resp_valid === 1'b1) begin
        if (exp_q.size() == 0) check("resp_unexpected", 64'(sr_resp_valid), 64'd0);
        else check("status", sr_resp_data, exp_q.pop_front());
      end
    end
  end

  initial begin : driver
    all_idle();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 0;

    // reset state
    check("reset_mode", 64'(mode), 64'(IMODE));
    sr_rd(); tick();
    tick();

    // three reads outstanding, switch to mode 2
    m_arvalid = 1; s_arready = 1;
    repeat (3) tick();
    m_arvalid = 0;
    sr_wr(64'd2); tick();
    m_arvalid = 1; s_arready = 1;
    #1 check("drain_ar_closed", 64'(m_arready), 64'd0);
    tick();
    rvalid = 1; rready = 1; rlast = 1;
    repeat (3) tick();
    rvalid = 0; rready = 0; rlast = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_ar_fire) break;
    end
    check("ar_after_switch", 64'(last_ar_fire), 64'd1);
    check("mode_now_2", 64'(mode), 64'd2);
    m_arvalid = 0;
    rvalid = 1; rready = 1; rlast = 1; tick();
    rvalid = 0; rready = 0; rlast = 0;

    // mode write while AR is presented but not accepted
    m_arvalid = 1; s_arready = 0;
    sr_wr(64'd1); tick();
    #1 check("inflight_hold", 64'(s_arvalid), 64'd1);
    tick();
    tick();
    s_arready = 1; tick();
    m_arvalid = 0;
    sr_rd();
    #1 check("closed_after_hs", 64'(m_arready), 64'd0);
    tick();
    rvalid = 1; rready = 1; rlast = 1; tick();
    rvalid = 0; rready = 0; rlast = 0;
    repeat (4) tick();
    check("mode_now_1", 64'(mode), 64'd1);

    // last write wins during drain, then illegal writes
    m_arvalid = 1; s_arready = 1; tick();
    m_arvalid = 0;
    sr_wr(64'd2); tick();
    sr_wr(64'd0); tick();
    rvalid = 1; rready = 1; rlast = 1; tick();
    rvalid = 0; rready = 0; rlast = 0;
    repeat (4) tick();
    check("last_write_wins", 64'(mode), 64'd0);
    sr_wr(64'd3); tick();
    sr_wr(64'h5); tick();
    check("bad_write_mode", 64'(mode), 64'd0);
    sr_rd(); tick();
    sr_rd(); tick();
    tick();

    // write counter saturation and reopen
    m_awvalid = 1; s_awready = 1;
    repeat (255) tick();
    #1 check("aw_full", 64'(m_awready), 64'd0);
    tick();
    sr_rd(); tick();
    bvalid = 1; bready = 1; tick();
    bvalid = 0; bready = 0;
    #1 check("aw_reopen", 64'(m_awready), 64'd1);
    tick();
    m_awvalid = 0;
    bvalid = 1; bready = 1;
    repeat (255) tick();
    bvalid = 0; bready = 0;
    sr_rd(); tick();

    // simultaneous increment/decrement, then reset during drain
    m_arvalid = 1; s_arready = 1;
    repeat (2) tick();
    rvalid = 1; rready = 1; rlast = 1; tick();
    all_idle();
    sr_rd(); tick();
    sr_wr(64'd2); tick();
    tick();
    sr_rd(); tick();
    rst = 1; tick();
    rst = 0;
    check("rst_mode", 64'(mode), 64'(IMODE));
    sr_rd(); tick();
    tick();

    // randomized traffic
    for (int n = 0; n < 4000; n++) rand_cycle(40, 40, 4);
    all_idle();
    for (int n = 0; n < 600 && (e_rd > 0 || e_wr > 0); n++) begin
      rvalid = (e_rd > 0); rready = 1; rlast = 1;
      bvalid = (e_wr > 0); bready = 1;
      tick();
    end
    all_idle();
    sr_rd(); tick();
    repeat (5) tick();
    check("resp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
